// File: rtl/aes_result_streamer_if.sv
// aes_result_streamer_if: API output register port bus (ready-for-data plus one write word with routing)
// master: streamer side, drives the write word and samples api_o_rfd_in
// slave : API side, drives api_o_rfd_in and samples the write word
`ifndef C_LENGTH_ADDR_SLOT
`define C_LENGTH_ADDR_SLOT 4
`endif
`ifndef C_LENGTH_ADDR_FPGA
`define C_LENGTH_ADDR_FPGA 4
`endif
`ifndef C_LENGTH_ADDR_REG
`define C_LENGTH_ADDR_REG 8
`endif
`ifndef C_LENGTH_CMD
`define C_LENGTH_CMD 4
`endif
`ifndef C_LENGTH_DATA
`define C_LENGTH_DATA 64
`endif
`ifndef CMD_WR
`define CMD_WR 4'h2
`endif
interface aes_result_streamer_if;
  logic                          api_o_rfd_in;
  logic [`C_LENGTH_ADDR_SLOT-1:0] api_o_tgt_slot_out;
  logic [`C_LENGTH_ADDR_FPGA-1:0] api_o_tgt_fpga_out;
  logic [`C_LENGTH_ADDR_REG-1:0]  api_o_tgt_reg_out;
  logic [`C_LENGTH_CMD-1:0]       api_o_tgt_cmd_out;
  logic [`C_LENGTH_ADDR_REG-1:0]  api_o_src_reg_out;
  logic [`C_LENGTH_CMD-1:0]       api_o_src_cmd_out;
  logic [`C_LENGTH_DATA-1:0]      api_o_data_out;
  logic                          api_o_wr_en_out;
  modport master (
    input  api_o_rfd_in,
    output api_o_tgt_slot_out, api_o_tgt_fpga_out, api_o_tgt_reg_out, api_o_tgt_cmd_out,
    output api_o_src_reg_out, api_o_src_cmd_out, api_o_data_out, api_o_wr_en_out
  );
  modport slave (
    output api_o_rfd_in,
    input  api_o_tgt_slot_out, api_o_tgt_fpga_out, api_o_tgt_reg_out, api_o_tgt_cmd_out,
    input  api_o_src_reg_out, api_o_src_cmd_out, api_o_data_out, api_o_wr_en_out
  );
endinterface

// File: rtl/aes_result_streamer.sv
// aes_result_streamer: tracks aes_256 launches through its fixed latency and streams each ciphertext out as CMD_WR words
// Ports: api_clk_in/api_rst_n_in clock and async active-low reset; start_* launch pulse and return address;
// start_ready_out launch credit; ciphertext_in core output; api_o output register port (master modport);
// busy_out any work pending; overflow_out sticky rejected-launch flag.
// Optional macro AES_STREAMER_SEQ_WORD_EN adds a third word per result carrying a launch sequence number.
module aes_result_streamer #(
  parameter int AES_LATENCY = 29,
  parameter int FIFO_DEPTH  = 4,
  parameter int REG_BASE    = 6
) (
  input  logic                           api_clk_in,
  input  logic                           api_rst_n_in,
  input  logic                           start_in,
  input  logic [`C_LENGTH_ADDR_SLOT-1:0] start_slot_in,
  input  logic [`C_LENGTH_ADDR_FPGA-1:0] start_fpga_in,
  input  logic [`C_LENGTH_ADDR_REG-1:0]  start_reg_in,
  output logic                           start_ready_out,
  input  logic [127:0]                   ciphertext_in,
  aes_result_streamer_if.master          api_o,
  output logic                           busy_out,
  output logic                           overflow_out
);
  localparam int SW = `C_LENGTH_ADDR_SLOT;
  localparam int FW = `C_LENGTH_ADDR_FPGA;
  localparam int RW = `C_LENGTH_ADDR_REG;
  localparam int TW = SW + FW + RW;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
`ifdef AES_STREAMER_SEQ_WORD_EN
  localparam int QW = TW + 64;
  typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI, SEND_SEQ} state_t;
`else
  localparam int QW = TW;
  typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;
`endif
  logic [AES_LATENCY-1:0] r_vld;
  logic [QW-1:0]          r_tq [FIFO_DEPTH];
  logic [QW-1:0]          r_rf_tag [FIFO_DEPTH];
  logic [127:0]           r_rf_ct [FIFO_DEPTH];
  logic [AW-1:0]          r_tq_wp, r_tq_rp, r_rf_wp, r_rf_rp;
  logic [CW-1:0]          r_inf, r_cnt;
  logic                   r_ovf;
  state_t                 r_state, w_nxt;
  logic                   r_wr_en;
  logic [63:0]            r_data;
  logic [SW-1:0]          r_tslot;
  logic [FW-1:0]          r_tfpga;
  logic [RW-1:0]          r_treg, r_src;
  logic                   w_acc, w_cap, w_emit, w_pop, w_rfd;
  logic [1:0]             w_sel;
  logic [CW:0]            w_used;
  logic [QW-1:0]          w_tag, w_head;
  logic [127:0]           w_ct;
  logic [63:0]            w_word;
  logic [RW-1:0]          w_src;
`ifdef AES_STREAMER_SEQ_WORD_EN
  logic [63:0]            r_seq;
  assign w_tag  = {r_seq, start_slot_in, start_fpga_in, start_reg_in};
  assign w_word = w_sel[1] ? w_head[QW-1:TW] : w_sel[0] ? w_ct[127:64] : w_ct[63:0];
`else
  assign w_tag  = {start_slot_in, start_fpga_in, start_reg_in};
  assign w_word = w_sel[0] ? w_ct[127:64] : w_ct[63:0];
`endif
  assign w_rfd  = api_o.api_o_rfd_in;
  // outstanding work (in the core plus buffered) must always fit the result FIFO, so capture never overflows
  assign w_used = {1'b0, r_inf} + {1'b0, r_cnt};
  assign start_ready_out = api_rst_n_in & (w_used < (CW+1)'(FIFO_DEPTH));
  assign w_acc  = start_in & start_ready_out;
  assign w_cap  = r_vld[AES_LATENCY-1];
  assign w_head = r_rf_tag[r_rf_rp];
  assign w_ct   = r_rf_ct[r_rf_rp];
  assign w_src  = RW'(REG_BASE) + RW'(w_sel);
  always_ff @(posedge api_clk_in) begin
    if (w_acc) r_tq[r_tq_wp] <= w_tag;
    if (w_cap) begin
      r_rf_ct[r_rf_wp]  <= ciphertext_in;
      r_rf_tag[r_rf_wp] <= r_tq[r_tq_rp];
    end
  end
  // IDLE with a result and rfd sends the low word straight away, giving the 2-cycle capture-to-write latency
  always_comb begin
    w_nxt  = r_state;
    w_emit = 1'b0;
    w_sel  = 2'd0;
    w_pop  = 1'b0;
    case (r_state)
      IDLE: if (r_cnt != '0) begin
        w_emit = w_rfd;
        w_nxt  = w_rfd ? SEND_HI : SEND_LO;
      end
      SEND_LO: if (w_rfd) begin
        w_emit = 1'b1;
        w_nxt  = SEND_HI;
      end
      SEND_HI: if (w_rfd) begin
        w_emit = 1'b1;
        w_sel  = 2'd1;
`ifdef AES_STREAMER_SEQ_WORD_EN
        w_nxt  = SEND_SEQ;
`else
        w_pop  = 1'b1;
        w_nxt  = (r_cnt > CW'(1)) ? SEND_LO : IDLE;
`endif
      end
`ifdef AES_STREAMER_SEQ_WORD_EN
      SEND_SEQ: if (w_rfd) begin
        w_emit = 1'b1;
        w_sel  = 2'd2;
        w_pop  = 1'b1;
        w_nxt  = (r_cnt > CW'(1)) ? SEND_LO : IDLE;
      end
`endif
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge api_clk_in or negedge api_rst_n_in) begin
    if (!api_rst_n_in) begin
      r_vld   <= '0;
      r_tq_wp <= '0;
      r_tq_rp <= '0;
      r_rf_wp <= '0;
      r_rf_rp <= '0;
      r_inf   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_state <= IDLE;
      r_wr_en <= 1'b0;
      r_data  <= '0;
      r_tslot <= '0;
      r_tfpga <= '0;
      r_treg  <= '0;
      r_src   <= '0;
`ifdef AES_STREAMER_SEQ_WORD_EN
      r_seq   <= '0;
`endif
    end else begin
      r_vld   <= AES_LATENCY'({r_vld, w_acc});
      r_tq_wp <= r_tq_wp + AW'(w_acc);
      r_tq_rp <= r_tq_rp + AW'(w_cap);
      r_rf_wp <= r_rf_wp + AW'(w_cap);
      r_rf_rp <= r_rf_rp + AW'(w_pop);
      r_inf   <= r_inf + CW'(w_acc) - CW'(w_cap);
      r_cnt   <= r_cnt + CW'(w_cap) - CW'(w_pop);
      r_ovf   <= r_ovf | (start_in & ~start_ready_out);
      r_state <= w_nxt;
      r_wr_en <= w_emit;
`ifdef AES_STREAMER_SEQ_WORD_EN
      r_seq   <= r_seq + 64'(w_acc);
`endif
      if (w_emit) begin
        r_data <= w_word;
        r_src  <= w_src;
        {r_tslot, r_tfpga, r_treg} <= w_head[TW-1:0];
      end
    end
  end
  assign api_o.api_o_wr_en_out    = r_wr_en;
  assign api_o.api_o_data_out     = r_data;
  assign api_o.api_o_src_reg_out  = r_src;
  assign api_o.api_o_tgt_slot_out = r_tslot;
  assign api_o.api_o_tgt_fpga_out = r_tfpga;
  assign api_o.api_o_tgt_reg_out  = r_treg;
  assign api_o.api_o_tgt_cmd_out  = `CMD_WR;
  assign api_o.api_o_src_cmd_out  = `CMD_WR;
  assign busy_out     = (r_inf != '0) | (r_cnt != '0) | (r_state != IDLE);
  assign overflow_out = r_ovf;
endmodule

// File: tb/tb_aes_result_streamer.sv
// tb_aes_result_streamer: directed scoreboard bench for aes_result_streamer
module tb_aes_result_streamer;
  localparam int L  = 29;
  localparam int SW = `C_LENGTH_ADDR_SLOT;
  localparam int FW = `C_LENGTH_ADDR_FPGA;
  localparam int RW = `C_LENGTH_ADDR_REG;
`ifdef AES_STREAMER_SEQ_WORD_EN
  localparam int WPJ = 3;
`else
  localparam int WPJ = 2;
`endif
  typedef struct {
    logic [SW-1:0] s;
    logic [FW-1:0] f;
    logic [RW-1:0] r;
    logic [RW-1:0] src;
    logic [63:0]   d;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [SW-1:0] slot = '0;
  logic [FW-1:0] fpga = '0;
  logic [RW-1:0] regi = '0;
  logic [127:0] ct;
  logic start_ready, busy, ovf;
  int cyc = 0, errors = 0, checks = 0, n_wr = 0, c0, n0;
  longint seqn = 0;
  exp_t sb[$];
  exp_t me;
  int wq[$];
  aes_result_streamer_if bus();
  aes_result_streamer #(.AES_LATENCY(L), .FIFO_DEPTH(4), .REG_BASE(6)) dut (
    .api_clk_in(clk), .api_rst_n_in(rst_n), .start_in(start),
    .start_slot_in(slot), .start_fpga_in(fpga), .start_reg_in(regi),
    .start_ready_out(start_ready), .ciphertext_in(ct), .api_o(bus),
    .busy_out(busy), .overflow_out(ovf)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [127:0] ct_of(input int c);
    return 128'h0123456789abcdef_fedcba9876543210 ^ {96'd0, 32'(c)};
  endfunction
  assign ct = ct_of(cyc);
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) if (rst_n && bus.api_o_wr_en_out) begin
    n_wr++;
    wq.push_back(cyc);
    if (sb.size() == 0) check("unexpected_write", bus.api_o_data_out, 64'hx);
    else begin
      me = sb.pop_front();
      check("wr_data", bus.api_o_data_out, me.d);
      check("wr_src_reg", 64'(bus.api_o_src_reg_out), 64'(me.src));
      check("wr_tgt", 64'({bus.api_o_tgt_slot_out, bus.api_o_tgt_fpga_out, bus.api_o_tgt_reg_out}),
            64'({me.s, me.f, me.r}));
    end
  end
  task automatic launch(input int s, input int f, input int r, input logic ok);
    logic [127:0] c;
    slot = SW'(s); fpga = FW'(f); regi = RW'(r); start = 1'b1;
    check("start_ready", 64'(start_ready), 64'(ok));
    if (ok) begin
      c = ct_of(cyc + L);
      sb.push_back('{SW'(s), FW'(f), RW'(r), RW'(6), c[63:0]});
      sb.push_back('{SW'(s), FW'(f), RW'(r), RW'(7), c[127:64]});
`ifdef AES_STREAMER_SEQ_WORD_EN
      sb.push_back('{SW'(s), FW'(f), RW'(r), RW'(8), 64'(seqn)});
`endif
      seqn++;
    end
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_drain(input int max);
    int i = 0;
    while (sb.size() != 0 && i < max) begin
      @(negedge clk);
      i++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask
  initial begin
    bus.api_o_rfd_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_en", 64'(bus.api_o_wr_en_out), 64'd0);
    check("rst_data", bus.api_o_data_out, 64'd0);
    check("rst_src_reg", 64'(bus.api_o_src_reg_out), 64'd0);
    check("rst_tgt", 64'({bus.api_o_tgt_slot_out, bus.api_o_tgt_fpga_out, bus.api_o_tgt_reg_out}), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_overflow", 64'(ovf), 64'd0);
    check("rst_start_ready", 64'(start_ready), 64'd0);
    check("rst_tgt_cmd", 64'(bus.api_o_tgt_cmd_out), 64'(`CMD_WR));
    check("rst_src_cmd", 64'(bus.api_o_src_cmd_out), 64'(`CMD_WR));
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 64'(start_ready), 64'd1);
    // single job: writes at launch + L + 2 and + L + 3
    bus.api_o_rfd_in = 1'b1;
    wq.delete();
    c0 = cyc;
    launch(2, 3, 0, 1'b1);
    wait_drain(60);
    check("single_nwr", 64'(wq.size()), 64'(WPJ));
    if (wq.size() >= 2) begin
      check("single_lo_cycle", 64'(wq[0]), 64'(c0 + L + 2));
      check("single_hi_cycle", 64'(wq[1]), 64'(c0 + L + 3));
    end
    check("single_idle_busy", 64'(busy), 64'd0);
    // credit exhaustion with rfd low
    bus.api_o_rfd_in = 1'b0;
    for (int i = 0; i < 5; i++) launch(i, 1, 16 + i, i < 4);
    check("overflow_set", 64'(ovf), 64'd1);
    n0 = n_wr;
    repeat (40) @(negedge clk);
    check("no_write_rfd_low", 64'(n_wr - n0), 64'd0);
    check("credit_busy", 64'(busy), 64'd1);
    check("credit_ready_low", 64'(start_ready), 64'd0);
    bus.api_o_rfd_in = 1'b1;
    wait_drain(60);
    check("credit_nwr", 64'(n_wr - n0), 64'(4 * WPJ));
    check("overflow_sticky", 64'(ovf), 64'd1);
    // backpressure between the two words
    bus.api_o_rfd_in = 1'b0;
    launch(5, 6, 7, 1'b1);
    repeat (L + 4) @(negedge clk);
    wq.delete();
    bus.api_o_rfd_in = 1'b1;
    c0 = cyc;
    @(negedge clk);
    bus.api_o_rfd_in = 1'b0;
    repeat (2) @(negedge clk);
    bus.api_o_rfd_in = 1'b1;
    wait_drain(20);
    check("bp_nwr", 64'(wq.size()), 64'(WPJ));
    if (wq.size() >= 2) begin
      check("bp_lo_cycle", 64'(wq[0]), 64'(c0 + 1));
      check("bp_hi_cycle", 64'(wq[1]), 64'(c0 + 4));
    end
    // streaming: back-to-back jobs give back-to-back words
    wq.delete();
    for (int i = 0; i < 4; i++) launch(8 + i, i, 100 + i, 1'b1);
    wait_drain(60);
    check("stream_nwr", 64'(wq.size()), 64'(4 * WPJ));
    if (wq.size() == 4 * WPJ)
      for (int i = 1; i < 4 * WPJ; i++) check("stream_consecutive", 64'(wq[i] - wq[0]), 64'(i));
    // reset while the high word is pending and two jobs are in flight
    launch(1, 2, 3, 1'b1);
    repeat (4) @(negedge clk);
    launch(4, 5, 6, 1'b1);
    launch(7, 8, 9, 1'b1);
    begin
      int i = 0;
      while (!bus.api_o_wr_en_out && i < 60) begin
        @(negedge clk);
        i++;
      end
    end
    check("midrst_found_write", 64'(bus.api_o_wr_en_out), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_wr_en", 64'(bus.api_o_wr_en_out), 64'd0);
    check("midrst_data", bus.api_o_data_out, 64'd0);
    check("midrst_tgt", 64'({bus.api_o_tgt_slot_out, bus.api_o_tgt_fpga_out, bus.api_o_tgt_reg_out}), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    sb.delete();
    seqn = 0;
    @(negedge clk);
    rst_n = 1'b1;
    n0 = n_wr;
    repeat (50) @(negedge clk);
    check("midrst_no_writes", 64'(n_wr - n0), 64'd0);
    check("midrst_busy_after", 64'(busy), 64'd0);
    check("midrst_ready", 64'(start_ready), 64'd1);
    check("midrst_overflow_clr", 64'(ovf), 64'd0);
    // sequence numbering restarts from zero after reset
    wq.delete();
    for (int i = 0; i < 3; i++) launch(3, 3, 50 + i, 1'b1);
    wait_drain(60);
    check("post_rst_nwr", 64'(wq.size()), 64'(3 * WPJ));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
